// File: rtl/seq_comparator_pkg.sv
// Shared definitions for the digit-serial comparator: FSM encoding and default sizing.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 2;

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module comparator_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: scans operands MSB-first, DIGIT bits per cycle,
// and stops at the first differing digit.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("seq_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             dig_gt, dig_eq, dig_lt;
  logic [WIDTH-1:0] msb_flip;

  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[WIDTH-1 -: DIGIT]),
    .y  (b_q[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  // Offset-binary: flipping both sign bits turns a signed compare into an unsigned one.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a ^ msb_flip;
          b_d     = b ^ msb_flip;
          cnt_d   = CW'(NDIG);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - CW'(1);
        if (!dig_eq) begin
          gt_d    = dig_gt;
          lt_d    = dig_lt;
          state_d = DONE;
        end else if (cnt_q == CW'(1)) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      gt_d    = 1'b0;
      eq_d    = 1'b0;
      lt_d    = 1'b0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, ≥2.
REQ-002 SHALL have parameter DIGIT, default 2: bits compared per cycle; WIDTH mod DIGIT == 0, enforced by elaboration check.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request a comparison; sampled each rising edge.
REQ-006 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 clear  input  1  synchronous abort/clear.
REQ-008 a  input  WIDTH  operand A; sampled with start.
REQ-009 b  input  WIDTH  operand B; sampled with start.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 gt / eq / lt  output  1 each  registered result: A>B, A==B, A<B.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 start SHALL be accepted in IDLE or DONE only; accept edge captures a, b and signed_mode, loads digit counter = WIDTH/DIGIT, clears gt/eq/lt, enters RUN.
REQ-015 On capture with signed_mode=1, MSB of both operands SHALL be inverted (offset-binary), so the unsigned digit compare yields the signed result.
REQ-016 In RUN, each cycle SHALL compare the most-significant DIGIT bits of the captured A against B, then shift both left by DIGIT and decrement the counter.
REQ-017 First differing digit SHALL register gt or lt, terminating early into DONE.
REQ-018 If all WIDTH/DIGIT digits are equal, SHALL register eq=1 and enter DONE.
REQ-019 Latency: done SHALL be high in the cycle k+1 edges after the accept edge, k = 0-based index (MSB first) of the first differing digit; maximum WIDTH/DIGIT edges.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE unless start is accepted in that cycle.
REQ-021 Exactly one of gt/eq/lt SHALL be high from done until the next accept or clear; all zero while busy.
REQ-022 busy SHALL be high exactly while in RUN.
REQ-023 start while in RUN SHALL be ignored; operands and progress unaffected.
REQ-024 clear SHALL take priority over start and all FSM transitions: next state IDLE, busy/done/gt/eq/lt = 0, no done pulse for the aborted compare.
REQ-025 Start accepted in DONE SHALL still pulse done for the prior result; the new compare begins the same edge.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, gt=0, eq=0, lt=0, counter and operand registers 0.
REQ-027 Reset deassertion SHALL be synchronised externally; first start is accepted on the first edge after release.
REQ-028 Reset during RUN SHALL discard the compare with no done pulse.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH/DIGIT constants.
REQ-030 One combinational sub-module comparator_digit (parameter DIGIT; ports x, y, gt, eq, lt) SHALL perform the per-cycle digit compare; seq_comparator instantiates it once.
REQ-031 Outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Verification (WIDTH=8, DIGIT=2)
REQ-032 a=0xA5, b=0x5A, unsigned, start -> done 1 edge after accept, gt=1, eq=0, lt=0.
REQ-033 a=b=0x3C, unsigned -> busy high 4 cycles, done 4 edges after accept, eq=1.
REQ-034 a=0x80, b=0x01: signed_mode=1 -> lt=1; signed_mode=0 -> gt=1.
REQ-035 a=0x24, b=0x25, unsigned -> lt=1, done 4 edges after accept (last-digit difference).
REQ-036 a=b=0xFF start, clear 2 cycles later -> next edge busy=0, gt=eq=lt=0, no done pulse; then start a=0x01, b=0x00 while clear=0 -> gt=1 after 4 edges.
REQ-037 start with a=0x00, b=0xFF during RUN of a=0xC0, b=0xC1 -> ignored; first compare completes lt=1; rst_n pulse mid-RUN -> all outputs 0 immediately.
